// File: rtl/dac_output_sched.sv
`default_nettype none
// ============================================================================
//  Module      : dac_output_sched
//  Description : Routes one of four free-running modulator sample buses to a
//                pair of DAC channels. Generates the DAC sample clocks and
//                write strobes from a free-running phase counter. Inserts a
//                midscale mute of MUTE_CYC sample periods on every source
//                switch, so that the analog output never jumps directly
//                between two waveforms.
//
//  Ports       : clk            - sole clock, rising edge
//                rst            - synchronous active-high reset
//                src0..src3     - 14-bit sample buses (2ASK, QPSK, cos_1M, cos_500K)
//                sel_req        - requested source index for channel 1
//                sel_load       - one-cycle strobe requesting a switch to sel_req
//                da1data/da2data- registered DAC codes
//                da1_clk/da2_clk- DAC sample clocks
//                da1_wrt/da2_wrt- DAC write strobes (same waveform as clocks)
//                active_sel     - source index currently routed to channel 1
//                busy           - switch pending or mute in progress
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_output_sched #(
    parameter int          DIV      = 4,
    parameter int          MUTE_CYC = 16,
    parameter logic [13:0] MIDSCALE = 14'h2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] src0,
    input  logic [13:0] src1,
    input  logic [13:0] src2,
    input  logic [13:0] src3,
    input  logic [1:0]  sel_req,
    input  logic        sel_load,
    output logic [13:0] da1data,
    output logic [13:0] da2data,
    output logic        da1_clk,
    output logic        da2_clk,
    output logic        da1_wrt,
    output logic        da2_wrt,
    output logic [1:0]  active_sel,
    output logic        busy
);

    localparam int CNT_W  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int MUTE_W = (MUTE_CYC > 1) ? $clog2(MUTE_CYC) : 1;

    localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  C_CNT_HALF  = CNT_W'(DIV / 2);
    localparam logic [MUTE_W-1:0] C_MUTE_LAST = MUTE_W'(MUTE_CYC - 1);

    typedef enum logic [0:0] {
        ST_MUTE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [MUTE_W-1:0]  r_mute_cnt;
    logic [1:0]         r_pending;
    logic [1:0]         r_active_sel;
    logic               r_switch;      // switch requested in RUN, waiting for the tick
    logic               r_busy;
    logic               r_da_clk;
    logic [13:0]        r_da1data;
    logic [13:0]        r_da2data;

    logic               w_tick;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_run_sw;
    logic [13:0]        w_src [4];

    assign w_src[0] = src0;
    assign w_src[1] = src1;
    assign w_src[2] = src2;
    assign w_src[3] = src3;

    assign w_tick     = (r_cnt == C_CNT_LAST);
    assign w_cnt_next = w_tick ? '0 : r_cnt + 1'b1;

    // A fresh strobe replaces any earlier request: a differing index arms the
    // switch, the current index cancels it.
    always_comb begin
        w_run_sw = r_switch;
        if (sel_load) begin
            w_run_sw = (sel_req != r_active_sel);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_MUTE;
            r_cnt        <= '0;
            r_mute_cnt   <= '0;
            r_pending    <= 2'd0;
            r_active_sel <= 2'd0;
            r_switch     <= 1'b0;
            r_busy       <= 1'b1;
            r_da_clk     <= 1'b0;
            r_da1data    <= MIDSCALE;
            r_da2data    <= MIDSCALE;
        end else begin
            // Strobe timing is independent of the state machine. The clock
            // register is computed from the next count so it lines up with cnt.
            r_cnt    <= w_cnt_next;
            r_da_clk <= (w_cnt_next >= C_CNT_HALF);

            case (r_state)
                ST_RUN: begin
                    if (sel_load) begin
                        r_pending <= sel_req;
                    end
                    if (w_tick) begin
                        // The sample for the period starting now is still a
                        // live one; the mute begins with the following tick.
                        r_da1data <= w_src[r_active_sel];
                        r_da2data <= w_src[r_active_sel ^ 2'b01];
                        if (w_run_sw) begin
                            r_state    <= ST_MUTE;
                            r_mute_cnt <= '0;
                        end
                        r_switch <= 1'b0;
                        r_busy   <= w_run_sw;
                    end else begin
                        r_switch <= w_run_sw;
                        r_busy   <= w_run_sw;
                    end
                end

                default: begin  // ST_MUTE
                    if (sel_load) begin
                        r_pending <= sel_req;
                    end
                    r_busy <= 1'b1;
                    if (w_tick) begin
                        r_da1data <= MIDSCALE;
                        r_da2data <= MIDSCALE;
                        if (r_mute_cnt == C_MUTE_LAST) begin
                            r_mute_cnt <= '0;
                            // A strobe landing on the final tick restarts a
                            // full mute for the newly requested source.
                            if (!sel_load) begin
                                r_active_sel <= r_pending;
                                r_state      <= ST_RUN;
                                r_busy       <= 1'b0;
                            end
                        end else begin
                            r_mute_cnt <= r_mute_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign da1data    = r_da1data;
    assign da2data    = r_da2data;
    assign da1_clk    = r_da_clk;
    assign da2_clk    = r_da_clk;
    assign da1_wrt    = r_da_clk;
    assign da2_wrt    = r_da_clk;
    assign active_sel = r_active_sel;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dac_output_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_output_sched
//  Description : Self-checking bench for dac_output_sched. A sample-period
//                level reference model predicts every output each cycle;
//                directed scenarios are followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_output_sched;

    localparam int          DIV      = 4;
    localparam int          MUTE_CYC = 2;
    localparam logic [13:0] MID      = 14'h2000;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] src [4];
    logic [1:0]  sel_req;
    logic        sel_load;
    logic [13:0] da1data, da2data;
    logic        da1_clk, da2_clk, da1_wrt, da2_wrt;
    logic [1:0]  active_sel;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_phase;
    bit          m_muted;
    int          m_left;
    logic [1:0]  m_pend;
    logic [1:0]  m_act;
    bit          m_sw;
    logic [13:0] m_d1, m_d2;
    logic [13:0] prev_d1, prev_d2;

    dac_output_sched #(
        .DIV      (DIV),
        .MUTE_CYC (MUTE_CYC),
        .MIDSCALE (MID)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src0       (src[0]),
        .src1       (src[1]),
        .src2       (src[2]),
        .src3       (src[3]),
        .sel_req    (sel_req),
        .sel_load   (sel_load),
        .da1data    (da1data),
        .da2data    (da2data),
        .da1_clk    (da1_clk),
        .da2_clk    (da2_clk),
        .da1_wrt    (da1_wrt),
        .da2_wrt    (da2_wrt),
        .active_sel (active_sel),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock: apply inputs, update the model for that edge,
    // then compare every output just after the edge.
    task automatic step(input logic r, input logic ld, input logic [1:0] rq);
        bit   tick;
        logic exp_clk;
        rst      = r;
        sel_load = ld;
        sel_req  = rq;
        @(posedge clk);
        if (r) begin
            m_phase = 0;
            m_muted = 1'b1;
            m_left  = MUTE_CYC;
            m_pend  = 2'd0;
            m_act   = 2'd0;
            m_sw    = 1'b0;
            m_d1    = MID;
            m_d2    = MID;
        end else begin
            tick = (m_phase == DIV - 1);
            if (!m_muted) begin
                if (ld) begin
                    m_pend = rq;
                    m_sw   = (rq != m_act);
                end
                if (tick) begin
                    m_d1 = src[m_act];
                    m_d2 = src[m_act ^ 2'b01];
                    if (m_sw) begin
                        m_muted = 1'b1;
                        m_left  = MUTE_CYC;
                        m_sw    = 1'b0;
                    end
                end
            end else begin
                if (ld) m_pend = rq;
                if (tick) begin
                    m_d1 = MID;
                    m_d2 = MID;
                    m_left--;
                    if (m_left == 0) begin
                        if (ld) begin
                            m_left = MUTE_CYC;
                        end else begin
                            m_act   = m_pend;
                            m_muted = 1'b0;
                        end
                    end
                end
            end
            m_phase = (m_phase + 1) % DIV;
        end
        #1;
        exp_clk = (m_phase >= DIV / 2);
        check("da1data",    32'(da1data),    32'(m_d1));
        check("da2data",    32'(da2data),    32'(m_d2));
        check("da1_clk",    32'(da1_clk),    32'(exp_clk));
        check("da2_clk",    32'(da2_clk),    32'(exp_clk));
        check("da1_wrt",    32'(da1_wrt),    32'(da1_clk));
        check("da2_wrt",    32'(da2_wrt),    32'(da2_clk));
        check("active_sel", 32'(active_sel), 32'(m_act));
        check("busy",       32'(busy),       32'(m_muted || m_sw));
        if (da1_clk === 1'b1) begin
            check("da1_stable", 32'(da1data), 32'(prev_d1));
            check("da2_stable", 32'(da2data), 32'(prev_d2));
        end
        prev_d1 = da1data;
        prev_d2 = da2data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        src[0] = 14'h0100;
        src[1] = 14'h0200;
        src[2] = 14'h0300;
        src[3] = 14'h0400;
        rst = 1'b1; sel_load = 1'b0; sel_req = 2'd0;
        m_phase = 0; m_muted = 1'b1; m_left = MUTE_CYC; m_pend = 2'd0;
        m_act = 2'd0; m_sw = 1'b0; m_d1 = MID; m_d2 = MID;
        prev_d1 = MID; prev_d2 = MID;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0);
        check("rst_da1",  32'(da1data), 32'h2000);
        check("rst_busy", 32'(busy),    32'd1);
        check("rst_clk",  32'(da1_clk), 32'd0);

        // Start-up mute then source 0
        idle(14);
        check("start_da1",  32'(da1data),    32'h0100);
        check("start_da2",  32'(da2data),    32'h0200);
        check("start_busy", 32'(busy),       32'd0);

        // Switch to source 2
        step(1'b0, 1'b1, 2'd2);
        check("sw_busy", 32'(busy), 32'd1);
        idle(14);
        check("sw_da1", 32'(da1data),    32'h0300);
        check("sw_da2", 32'(da2data),    32'h0400);
        check("sw_act", 32'(active_sel), 32'd2);

        // Reselect current source: no mute
        step(1'b0, 1'b1, 2'd2);
        idle(8);
        check("same_busy", 32'(busy),    32'd0);
        check("same_da1",  32'(da1data), 32'h0300);

        // Requests during mute: last one wins
        step(1'b0, 1'b1, 2'd1);
        idle(5);
        step(1'b0, 1'b1, 2'd3);
        step(1'b0, 1'b1, 2'd1);
        idle(14);
        check("mute_da1", 32'(da1data),    32'h0200);
        check("mute_da2", 32'(da2data),    32'h0100);
        check("mute_act", 32'(active_sel), 32'd1);

        // Reset mid-mute
        step(1'b0, 1'b1, 2'd0);
        idle(6);
        step(1'b1, 1'b0, 2'd0);
        check("mrst_da1",  32'(da1data),    32'h2000);
        check("mrst_act",  32'(active_sel), 32'd0);
        check("mrst_busy", 32'(busy),       32'd1);
        check("mrst_clk",  32'(da1_clk),    32'd0);
        idle(14);
        check("mrst_run", 32'(da1data), 32'h0100);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++) src[k] = 14'($urandom);
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 9) == 0),
                 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
